// File: rtl/hht_csr_writer.sv
// Streaming dense-to-CSR encoder: consumes a row-major dense matrix and emits the
// row-pointer/column-index image on write port 1 and the value array on write port 2.
module hht_csr_writer #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DIM_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [AW-1:0]    row_base,
    input  logic [AW-1:0]    col_base,
    input  logic [AW-1:0]    val_base,
    input  logic [DIM_W-1:0] n_rows,
    input  logic [DIM_W-1:0] n_cols,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             wr1_en,
    output logic [AW-1:0]    wr1_addr,
    output logic [31:0]      wr1_data,
    output logic             wr2_en,
    output logic [AW-1:0]    wr2_addr,
    output logic [DW-1:0]    wr2_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      nnz_count
);

    typedef enum logic [2:0] {IDLE, PTR0, STREAM, ROWEND, FIN} state_t;

    state_t           state, state_d;
    logic [AW-1:0]    row_base_q, col_base_q, val_base_q;
    logic [AW-1:0]    row_base_d, col_base_d, val_base_d;
    logic [DIM_W-1:0] n_rows_q, n_cols_q, n_rows_d, n_cols_d;
    logic [DIM_W-1:0] r, c, r_d, c_d;
    logic [31:0]      nnz, nnz_d;

    logic             in_ready_d, wr1_en_d, wr2_en_d, busy_d, done_d;
    logic [AW-1:0]    wr1_addr_d, wr2_addr_d;
    logic [31:0]      wr1_data_d, nnz_count_d;
    logic [DW-1:0]    wr2_data_d;

    // in_ready is itself registered and only ever high in STREAM, so it doubles as the state qualifier.
    logic handshake;
    assign handshake = in_valid && in_ready;

    // NOTE: every variable written here gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d     = state;
        row_base_d  = row_base_q;
        col_base_d  = col_base_q;
        val_base_d  = val_base_q;
        n_rows_d    = n_rows_q;
        n_cols_d    = n_cols_q;
        r_d         = r;
        c_d         = c;
        nnz_d       = nnz;
        in_ready_d  = 1'b0;
        wr1_en_d    = 1'b0;
        wr1_addr_d  = wr1_addr;
        wr1_data_d  = wr1_data;
        wr2_en_d    = 1'b0;
        wr2_addr_d  = wr2_addr;
        wr2_data_d  = wr2_data;
        busy_d      = busy;
        done_d      = 1'b0;
        nnz_count_d = nnz_count;

        case (state)
            IDLE: begin
                if (start) begin
                    row_base_d = row_base;
                    col_base_d = col_base;
                    val_base_d = val_base;
                    n_rows_d   = n_rows;
                    n_cols_d   = n_cols;
                    nnz_d      = 32'd0;
                    busy_d     = 1'b1;
                    state_d    = PTR0;
                end
            end
            PTR0: begin
                wr1_en_d   = 1'b1;
                wr1_addr_d = row_base_q;
                wr1_data_d = 32'd0;
                if (n_rows_q == '0 || n_cols_q == '0) begin
                    state_d = FIN;
                end else begin
                    r_d        = '0;
                    c_d        = '0;
                    in_ready_d = 1'b1;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                in_ready_d = 1'b1;
                if (handshake) begin
                    if (in_data != '0) begin
                        wr1_en_d   = 1'b1;
                        wr1_addr_d = col_base_q + AW'(nnz);
                        wr1_data_d = 32'(c);
                        wr2_en_d   = 1'b1;
                        wr2_addr_d = val_base_q + AW'(nnz);
                        wr2_data_d = in_data;
                        nnz_d      = nnz + 32'd1;
                    end
                    if (c == n_cols_q - DIM_W'(1)) begin
                        c_d        = '0;
                        in_ready_d = 1'b0;
                        state_d    = ROWEND;
                    end else begin
                        c_d = c + DIM_W'(1);
                    end
                end
            end
            ROWEND: begin
                // nnz already counts this row's last element, accepted on the previous edge.
                wr1_en_d   = 1'b1;
                wr1_addr_d = row_base_q + AW'(r) + AW'(1);
                wr1_data_d = nnz;
                r_d        = r + DIM_W'(1);
                if (r == n_rows_q - DIM_W'(1)) begin
                    state_d = FIN;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = STREAM;
                end
            end
            FIN: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                nnz_count_d = nnz;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= IDLE;
            row_base_q <= '0;
            col_base_q <= '0;
            val_base_q <= '0;
            n_rows_q   <= '0;
            n_cols_q   <= '0;
            r          <= '0;
            c          <= '0;
            nnz        <= '0;
            in_ready   <= 1'b0;
            wr1_en     <= 1'b0;
            wr1_addr   <= '0;
            wr1_data   <= '0;
            wr2_en     <= 1'b0;
            wr2_addr   <= '0;
            wr2_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nnz_count  <= '0;
        end else begin
            state      <= state_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            val_base_q <= val_base_d;
            n_rows_q   <= n_rows_d;
            n_cols_q   <= n_cols_d;
            r          <= r_d;
            c          <= c_d;
            nnz        <= nnz_d;
            in_ready   <= in_ready_d;
            wr1_en     <= wr1_en_d;
            wr1_addr   <= wr1_addr_d;
            wr1_data   <= wr1_data_d;
            wr2_en     <= wr2_en_d;
            wr2_addr   <= wr2_addr_d;
            wr2_data   <= wr2_data_d;
            busy       <= busy_d;
            done       <= done_d;
            nnz_count  <= nnz_count_d;
        end
    end

endmodule

// File: tb/tb_hht_csr_writer.sv
// Self-checking bench for hht_csr_writer: directed and randomized matrices checked
// against a software CSR model of the expected write streams.
module tb_hht_csr_writer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DIM_W = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             start;
    logic [AW-1:0]    row_base, col_base, val_base;
    logic [DIM_W-1:0] n_rows, n_cols;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             wr1_en, wr2_en;
    logic [AW-1:0]    wr1_addr, wr2_addr;
    logic [31:0]      wr1_data;
    logic [DW-1:0]    wr2_data;
    logic             busy, done;
    logic [31:0]      nnz_count;

    hht_csr_writer #(.DW(DW), .AW(AW), .DIM_W(DIM_W)) dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .row_base(row_base), .col_base(col_base), .val_base(val_base),
        .n_rows(n_rows), .n_cols(n_cols),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
        .busy(busy), .done(done), .nnz_count(nnz_count)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mat [0:255];
    logic [63:0] wr1_log[$], wr2_log[$], exp1[$], exp2[$];
    bit          in_ready_seen = 1'b0;
    bit          prev_nz_hs = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write logger; also demands that wr2 fires exactly one cycle after each nonzero accept.
    always @(negedge Clk) begin
        if (wr1_en) wr1_log.push_back({wr1_addr, wr1_data});
        if (wr2_en) wr2_log.push_back({wr2_addr, wr2_data});
        if (in_ready) in_ready_seen = 1'b1;
        if (wr2_en || prev_nz_hs) check("wr2_timing", 64'(wr2_en), 64'(prev_nz_hs));
        prev_nz_hs = Rst && in_valid && in_ready && (in_data != '0);
    end

    // Software CSR model: expected write streams in issue order.
    task automatic build_expect(input int rows, input int cols, input logic [31:0] rb,
                                input logic [31:0] cb, input logic [31:0] vb, output int nnz);
        logic [31:0] a;
        exp1.delete();
        exp2.delete();
        nnz = 0;
        exp1.push_back({rb, 32'd0});
        if (rows == 0 || cols == 0) return;
        for (int i = 0; i < rows; i++) begin
            for (int j = 0; j < cols; j++) begin
                if (mat[i*cols+j] != 0) begin
                    a = cb + 32'(nnz);
                    exp1.push_back({a, 32'(j)});
                    a = vb + 32'(nnz);
                    exp2.push_back({a, mat[i*cols+j]});
                    nnz++;
                end
            end
            a = rb + 32'(i + 1);
            exp1.push_back({a, 32'(nnz)});
        end
    endtask

    task automatic fill_random(input int count, input int density_pct);
        for (int i = 0; i < 256; i++)
            mat[i] = (i < count && $urandom_range(99) < density_pct) ? $urandom : 32'd0;
    endtask

    task automatic encode(input string name, input int rows, input int cols,
                          input logic [31:0] rb, input logic [31:0] cb, input logic [31:0] vb,
                          input int gap_pct, input bit poke_start, input bit check_latency);
        int nnz, idx, cycles, total;
        bit hs, got_done;
        build_expect(rows, cols, rb, cb, vb, nnz);
        total = (rows == 0 || cols == 0) ? 0 : rows * cols;
        wr1_log.delete();
        wr2_log.delete();
        in_ready_seen = 1'b0;
        row_base = rb; col_base = cb; val_base = vb;
        n_rows = DIM_W'(rows); n_cols = DIM_W'(cols);
        start = 1'b1;
        idx = 0; cycles = 0; got_done = 1'b0;
        while (!got_done && cycles < 5000) begin
            if (idx < total && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = mat[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            hs = in_valid && in_ready;
            @(posedge Clk); #1;
            cycles++;
            start = poke_start && cycles == 6;
            if (start) begin
                row_base = $urandom; col_base = $urandom; val_base = $urandom;
                n_rows = DIM_W'(1); n_cols = DIM_W'(1);
            end
            if (cycles == 1) check({name, ":busy_rise"}, 64'(busy), 64'd1);
            if (hs) idx++;
            got_done = done;
        end
        in_valid = 1'b0;
        check({name, ":done_seen"}, 64'(got_done), 64'd1);
        check({name, ":consumed"}, 64'(idx), 64'(total));
        check({name, ":nnz_count"}, 64'(nnz_count), 64'(nnz));
        check({name, ":busy_fall"}, 64'(busy), 64'd0);
        if (check_latency)
            check({name, ":latency"}, 64'(cycles), 64'(rows * (cols + 1) + 3));
        if (rows == 0) check({name, ":in_ready_quiet"}, 64'(in_ready_seen), 64'd0);
        @(posedge Clk); #1;
        check({name, ":done_pulse"}, 64'(done), 64'd0);
        check({name, ":wr1_count"}, 64'(wr1_log.size()), 64'(exp1.size()));
        check({name, ":wr2_count"}, 64'(wr2_log.size()), 64'(exp2.size()));
        for (int i = 0; i < exp1.size() && i < wr1_log.size(); i++)
            check($sformatf("%s:wr1[%0d]", name, i), wr1_log[i], exp1[i]);
        for (int i = 0; i < exp2.size() && i < wr2_log.size(); i++)
            check($sformatf("%s:wr2[%0d]", name, i), wr2_log[i], exp2[i]);
        if (rows > 0 && cols > 0 && wr1_log.size() > 0)
            check({name, ":final_row_ptr"}, 64'(wr1_log[wr1_log.size()-1][31:0]), 64'(nnz));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":flags"}, 64'({in_ready, wr1_en, wr2_en, busy, done}), 64'd0);
        check({tag, ":wr1"}, {wr1_addr, wr1_data}, 64'd0);
        check({tag, ":wr2"}, {wr2_addr, wr2_data}, 64'd0);
        check({tag, ":nnz_count"}, 64'(nnz_count), 64'd0);
    endtask

    initial begin
        int idx;
        bit hs;
        Rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        row_base = '0; col_base = '0; val_base = '0; n_rows = '0; n_cols = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Rst = 1'b1;
        @(posedge Clk); #1;

        // 2x2 identity
        for (int i = 0; i < 256; i++) mat[i] = 32'd0;
        mat[0] = 32'd1;
        mat[3] = 32'd1;
        encode("identity2x2", 2, 2, 32'd25940, 32'd2440, 32'd90, 0, 1'b0, 1'b1);

        // all-zero 3x4
        for (int i = 0; i < 256; i++) mat[i] = 32'd0;
        encode("zero3x4", 3, 4, 32'd25940, 32'd2440, 32'd90, 0, 1'b0, 1'b1);

        // empty matrix
        encode("rows0", 0, 4, 32'd25940, 32'd2440, 32'd90, 0, 1'b0, 1'b1);

        // 16x16 random sparse with input gaps
        fill_random(256, 25);
        encode("sparse16", 16, 16, $urandom, $urandom, $urandom, 30, 1'b0, 1'b0);

        // start pulsed mid-stream with scrambled inputs
        fill_random(16, 60);
        encode("start_ignored", 4, 4, 32'h1000, 32'h2000, 32'h3000, 0, 1'b1, 1'b1);

        // address wrap near the top of the address space
        fill_random(15, 70);
        encode("addr_wrap", 5, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 20, 1'b0, 1'b0);

        // mid-row reset on a 4x4, then a fresh encode
        fill_random(16, 100);
        for (int i = 0; i < 16; i++) if (mat[i] == 0) mat[i] = 32'd7;
        row_base = 32'h500; col_base = 32'h600; val_base = 32'h700;
        n_rows = DIM_W'(4); n_cols = DIM_W'(4);
        start = 1'b1;
        idx = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            in_valid = 1'b1;
            in_data  = mat[idx];
            hs = in_valid && in_ready;
            @(posedge Clk); #1;
            start = 1'b0;
            if (hs) idx++;
        end
        check("rst_mid:reached", 64'(idx), 64'd6);
        Rst = 1'b0;
        @(posedge Clk); #1;
        check_all_zero("rst_mid");
        Rst = 1'b1;
        wr1_log.delete();
        wr2_log.delete();
        repeat (6) begin
            @(posedge Clk); #1;
        end
        check("rst_mid:no_wr1", 64'(wr1_log.size()), 64'd0);
        check("rst_mid:no_wr2", 64'(wr2_log.size()), 64'd0);
        check("rst_mid:idle", 64'({in_ready, busy, done}), 64'd0);
        in_valid = 1'b0;
        encode("after_rst", 4, 4, 32'h500, 32'h600, 32'h700, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
